// File: rtl/fsm_command_issuer.sv
// Host-side command issuer for the control unit's start/mode/done handshake.
// Issues one start pulse per command, then counts WAIT cycles until done or timeout.
module fsm_command_issuer #(
    parameter int unsigned TIMEOUT = 16,
    parameter int unsigned CNT_W   = 8
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             cmd_valid,
    input  logic             cmd_mode,
    output logic             cmd_ready,
    output logic             start,
    output logic             mode,
    input  logic             e,
    input  logic             s0,
    input  logic             s1,
    input  logic             s2,
    input  logic             done,
    output logic             busy,
    output logic             rsp_valid,
    output logic             rsp_timeout,
    output logic [CNT_W-1:0] rsp_cycles,
    output logic [CNT_W-1:0] rsp_ecount,
    output logic [2:0]       rsp_sel,
    output logic             rsp_mode
);

    typedef enum logic [1:0] {StIdle, StIssue, StWait, StReport} state_e;

    localparam logic [CNT_W-1:0] CntMax     = '1;
    localparam logic [CNT_W-1:0] TimeoutVal = CNT_W'(TIMEOUT);

    state_e           state_q, state_d;
    logic             mode_q, mode_d;
    logic [CNT_W-1:0] cycles_q, cycles_d, cycles_inc;
    logic [CNT_W-1:0] ecount_q, ecount_d, ecount_inc;
    logic             rsp_timeout_q, rsp_timeout_d;
    logic [CNT_W-1:0] rsp_cycles_q, rsp_cycles_d;
    logic [CNT_W-1:0] rsp_ecount_q, rsp_ecount_d;
    logic [2:0]       rsp_sel_q, rsp_sel_d;
    logic             rsp_mode_q, rsp_mode_d;
    logic             wait_exit;

    // Saturating increments; cycles saturate too so a large TIMEOUT cannot wrap.
    always_comb begin
        cycles_inc = (cycles_q == CntMax) ? CntMax : cycles_q + CNT_W'(1);
        ecount_inc = (e && (ecount_q != CntMax)) ? ecount_q + CNT_W'(1) : ecount_q;
        wait_exit  = (state_q == StWait) && (done || (cycles_inc == TimeoutVal));
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:   if (cmd_valid) state_d = StIssue;
            StIssue:  state_d = StWait;
            StWait:   if (wait_exit) state_d = StReport;
            StReport: state_d = StIdle;
            default:  state_d = StIdle;
        endcase
    end

    always_comb begin
        cmd_ready = (state_q == StIdle);
        start     = (state_q == StIssue);
        busy      = (state_q != StIdle);
        rsp_valid = (state_q == StReport);
    end

    // Datapath: the response is captured on the final WAIT edge so it is valid in REPORT.
    always_comb begin
        mode_d        = mode_q;
        cycles_d      = cycles_q;
        ecount_d      = ecount_q;
        rsp_timeout_d = rsp_timeout_q;
        rsp_cycles_d  = rsp_cycles_q;
        rsp_ecount_d  = rsp_ecount_q;
        rsp_sel_d     = rsp_sel_q;
        rsp_mode_d    = rsp_mode_q;
        if ((state_q == StIdle) && cmd_valid) begin
            mode_d = cmd_mode;
        end
        if (state_q == StIssue) begin
            cycles_d = '0;
            ecount_d = '0;
        end
        if (state_q == StWait) begin
            cycles_d = cycles_inc;
            ecount_d = ecount_inc;
        end
        if (wait_exit) begin
            rsp_timeout_d = ~done;
            rsp_cycles_d  = cycles_inc;
            rsp_ecount_d  = ecount_inc;
            rsp_sel_d     = {s2, s1, s0};
            rsp_mode_d    = mode_q;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            mode_q        <= 1'b0;
            cycles_q      <= '0;
            ecount_q      <= '0;
            rsp_timeout_q <= 1'b0;
            rsp_cycles_q  <= '0;
            rsp_ecount_q  <= '0;
            rsp_sel_q     <= '0;
            rsp_mode_q    <= 1'b0;
        end else begin
            mode_q        <= mode_d;
            cycles_q      <= cycles_d;
            ecount_q      <= ecount_d;
            rsp_timeout_q <= rsp_timeout_d;
            rsp_cycles_q  <= rsp_cycles_d;
            rsp_ecount_q  <= rsp_ecount_d;
            rsp_sel_q     <= rsp_sel_d;
            rsp_mode_q    <= rsp_mode_d;
        end
    end

    assign mode        = mode_q;
    assign rsp_timeout = rsp_timeout_q;
    assign rsp_cycles  = rsp_cycles_q;
    assign rsp_ecount  = rsp_ecount_q;
    assign rsp_sel     = rsp_sel_q;
    assign rsp_mode    = rsp_mode_q;

endmodule

// File: tb/tb_fsm_command_issuer.sv
// Directed bench for fsm_command_issuer; expected responses are queued when a
// command is driven and compared by a monitor when rsp_valid pulses.
module tb_fsm_command_issuer;

    typedef struct packed {
        logic       to;
        logic [7:0] cyc;
        logic [7:0] ec;
        logic [2:0] sel;
        logic       m;
    } rsp_t;

    logic       clock = 1'b0;
    logic       reset;
    logic       cmd_valid, cmd_mode, cmd_ready;
    logic       start, mode, busy;
    logic       e, s0, s1, s2, done;
    logic       rsp_valid, rsp_timeout, rsp_mode;
    logic [7:0] rsp_cycles, rsp_ecount;
    logic [2:0] rsp_sel;

    int   checks = 0;
    int   errors = 0;
    rsp_t exp_q[$];
    logic prev_start = 1'b0;
    logic prev_busy  = 1'b0;
    logic prev_mode  = 1'b0;

    fsm_command_issuer #(.TIMEOUT(16), .CNT_W(8)) dut (
        .clock      (clock),
        .reset      (reset),
        .cmd_valid  (cmd_valid),
        .cmd_mode   (cmd_mode),
        .cmd_ready  (cmd_ready),
        .start      (start),
        .mode       (mode),
        .e          (e),
        .s0         (s0),
        .s1         (s1),
        .s2         (s2),
        .done       (done),
        .busy       (busy),
        .rsp_valid  (rsp_valid),
        .rsp_timeout(rsp_timeout),
        .rsp_cycles (rsp_cycles),
        .rsp_ecount (rsp_ecount),
        .rsp_sel    (rsp_sel),
        .rsp_mode   (rsp_mode)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Monitor: invariants every cycle plus scoreboard compare on each report.
    always @(negedge clock) begin
        if (reset) begin
            prev_start <= 1'b0;
            prev_busy  <= 1'b0;
            prev_mode  <= 1'b0;
        end else begin
            check("ready_only_idle", 32'(cmd_ready), 32'(!busy));
            check("start_single", 32'(start && prev_start), 32'd0);
            if (busy && prev_busy) check("mode_stable", 32'(mode), 32'(prev_mode));
            if (rsp_valid) begin
                check("rsp_expected", 32'(exp_q.size() > 0), 32'd1);
                if (exp_q.size() > 0) begin
                    rsp_t x;
                    x = exp_q.pop_front();
                    check("rsp_timeout", 32'(rsp_timeout), 32'(x.to));
                    check("rsp_cycles", 32'(rsp_cycles), 32'(x.cyc));
                    check("rsp_ecount", 32'(rsp_ecount), 32'(x.ec));
                    check("rsp_sel", 32'(rsp_sel), 32'(x.sel));
                    check("rsp_mode", 32'(rsp_mode), 32'(x.m));
                end
            end
            prev_start <= start;
            prev_busy  <= busy;
            prev_mode  <= mode;
        end
    end

    // One full command: n_wait WAIT cycles, e taken from e_pat bit i on WAIT cycle i+1.
    task automatic do_cmd(input logic m, input int n_wait, input logic [31:0] e_pat,
                          input logic [2:0] sel_last, input logic with_done, input logic spur);
        rsp_t x;
        int   ec;
        ec = 0;
        for (int i = 0; i < n_wait; i++) ec += int'(e_pat[i]);
        x.to  = !with_done;
        x.cyc = 8'(n_wait);
        x.ec  = 8'(ec);
        x.sel = sel_last;
        x.m   = m;
        exp_q.push_back(x);
        if (spur) begin
            done = 1'b1;
            tick();
            check("spur_idle_ready", 32'(cmd_ready), 32'd1);
        end
        cmd_valid = 1'b1;
        cmd_mode  = m;
        tick();
        cmd_valid = 1'b0;
        cmd_mode  = !m;
        check("issue_start", 32'(start), 32'd1);
        check("issue_busy", 32'(busy), 32'd1);
        check("issue_mode", 32'(mode), 32'(m));
        tick();
        check("wait_no_start", 32'(start), 32'd0);
        for (int i = 0; i < n_wait; i++) begin
            e    = e_pat[i];
            {s2, s1, s0} = (i == n_wait - 1) ? sel_last : 3'(i);
            done = with_done && (i == n_wait - 1);
            tick();
            if (i < n_wait - 1) check("no_early_rsp", 32'(rsp_valid), 32'd0);
        end
        done = 1'b0;
        e    = 1'b0;
        check("report_valid", 32'(rsp_valid), 32'd1);
        tick();
        check("back_idle", 32'(cmd_ready), 32'd1);
        check("rsp_pulse", 32'(rsp_valid), 32'd0);
        check("rsp_hold_cycles", 32'(rsp_cycles), 32'(n_wait));
    endtask

    initial begin
        reset = 1'b1;
        cmd_valid = 1'b0; cmd_mode = 1'b0;
        e = 1'b0; s0 = 1'b0; s1 = 1'b0; s2 = 1'b0; done = 1'b0;
        repeat (2) @(posedge clock);
        #1 reset = 1'b0;
        #1;
        check("rst_cycles", 32'(rsp_cycles), 32'd0);
        check("rst_ecount", 32'(rsp_ecount), 32'd0);
        check("rst_sel", 32'(rsp_sel), 32'd0);
        check("rst_flags", 32'({rsp_valid, rsp_timeout, rsp_mode, start, busy}), 32'd0);
        check("rst_ready", 32'(cmd_ready), 32'd1);
        tick();

        do_cmd(1'b1, 3, 32'b011, 3'b101, 1'b1, 1'b0);          // normal
        do_cmd(1'b0, 16, 32'hA5A5, 3'b110, 1'b0, 1'b0);        // timeout
        do_cmd(1'b1, 16, 32'h00F3, 3'b011, 1'b1, 1'b0);        // done on final cycle
        do_cmd(1'b0, 2, 32'b10, 3'b111, 1'b1, 1'b1);           // spurious done

        // Back-to-back with cmd_valid held high.
        exp_q.push_back('{to: 1'b0, cyc: 8'd1, ec: 8'd1, sel: 3'b110, m: 1'b0});
        exp_q.push_back('{to: 1'b0, cyc: 8'd1, ec: 8'd1, sel: 3'b110, m: 1'b1});
        cmd_valid = 1'b1;
        cmd_mode  = 1'b0;
        for (int c = 0; c < 2; c++) begin
            tick();
            check("b2b_start", 32'(start), 32'd1);
            check("b2b_mode", 32'(mode), 32'(c));
            cmd_mode = 1'b1;
            tick();
            check("b2b_wait_start", 32'(start), 32'd0);
            e = 1'b1; {s2, s1, s0} = 3'b110; done = 1'b1;
            tick();
            e = 1'b0; {s2, s1, s0} = 3'b000; done = 1'b0;
            check("b2b_report", 32'({rsp_valid, cmd_ready}), 32'b10);
            if (c == 1) cmd_valid = 1'b0;
            tick();
            check("b2b_idle_ready", 32'(cmd_ready), 32'd1);
        end
        tick();
        check("b2b_no_reaccept", 32'(busy), 32'd0);

        // Reset during WAIT cycle 2.
        cmd_valid = 1'b1; cmd_mode = 1'b1;
        tick();
        cmd_valid = 1'b0;
        tick();
        e = 1'b1;
        tick();
        #2 reset = 1'b1;
        #1;
        check("mid_rst_busy", 32'(busy), 32'd0);
        check("mid_rst_ready", 32'(cmd_ready), 32'd1);
        check("mid_rst_mode", 32'(mode), 32'd0);
        check("mid_rst_rsp", 32'({rsp_mode, rsp_timeout, rsp_ecount, rsp_cycles}), 32'd0);
        e = 1'b0;
        repeat (2) @(posedge clock);
        #1 reset = 1'b0;
        tick();
        check("post_rst_idle", 32'({rsp_valid, busy}), 32'd0);
        do_cmd(1'b0, 5, 32'b10110, 3'b011, 1'b1, 1'b0);

        repeat (3) tick();
        check("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
